// File: rtl/tt_dfd_clk_req_pkg.sv
// Shared types and widths for the DFD clock-request controller.
package tt_dfd_clk_req_pkg;

  typedef enum logic [1:0] {
    CLK_OFF   = 2'd0,
    CLK_WAKE  = 2'd1,
    CLK_ON    = 2'd2,
    CLK_DRAIN = 2'd3
  } clk_req_state_e;

  localparam int unsigned WAKE_COUNT_W = 16;
  localparam int unsigned ON_CYCLES_W  = 32;

  // Width needed to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tt_dfd_clk_req_cnt.sv
// Loadable saturating down-counter with a zero flag; used for wake and idle timing.
module tt_dfd_clk_req_cnt
  import tt_dfd_clk_req_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_c_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load wins over decrement; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/tt_dfd_clk_req_ctrl.sv
// Clock-request controller driving a clock-gating cell enable.
// Optional statistics counters: define TT_DFD_CLK_REQ_STATS_EN.
module tt_dfd_clk_req_ctrl
  import tt_dfd_clk_req_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned WAKE_CYC = 2,
  parameter int unsigned IDLE_CYC = 4,
  parameter int unsigned NUM_BUSY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_i,
  output logic [NUM_REQ-1:0]      ack_o,
  input  logic [NUM_BUSY-1:0]     busy_i,
  input  logic                    force_en_i,
`ifdef TT_DFD_CLK_REQ_STATS_EN
  input  logic                    stats_clr_i,
  output logic [WAKE_COUNT_W-1:0] wake_count_o,
  output logic [ON_CYCLES_W-1:0]  on_cycles_o,
`endif
  output logic                    gate_en_o,
  output logic                    gate_hyst_o,
  output logic                    clk_on_o
);

  localparam int unsigned WAKE_W    = cnt_width(WAKE_CYC);
  localparam int unsigned IDLE_W    = cnt_width(IDLE_CYC);
  localparam int unsigned WAKE_LOAD = (WAKE_CYC == 0) ? 0 : WAKE_CYC - 1;
  localparam int unsigned IDLE_LOAD = (IDLE_CYC == 0) ? 0 : IDLE_CYC - 1;

  clk_req_state_e     state_q;
  clk_req_state_e     state_d;
  logic               gate_en_q;
  logic               gate_en_d;
  logic               hyst_q;
  logic               hyst_d;
  logic               clk_on_q;
  logic               clk_on_d;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] ack_d;

  logic               any_act;
  logic               wake_load;
  logic               wake_dec;
  logic               wake_zero;
  logic               idle_load;
  logic [IDLE_W-1:0]  idle_load_val;
  logic               idle_dec;
  logic               idle_zero;
  logic               gate_off;

  assign any_act = (|req_i) | (|busy_i) | force_en_i;

  tt_dfd_clk_req_cnt #(.WIDTH(WAKE_W)) u_wake_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wake_load),
    .load_val_i (WAKE_W'(WAKE_LOAD)),
    .dec_i      (wake_dec),
    .zero_c_o   (wake_zero)
  );

  tt_dfd_clk_req_cnt #(.WIDTH(IDLE_W)) u_idle_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (idle_load),
    .load_val_i (idle_load_val),
    .dec_i      (idle_dec),
    .zero_c_o   (idle_zero)
  );

  // Next state, counter control and registered-output next values.
  always_comb begin
    state_d       = state_q;
    wake_load     = 1'b0;
    wake_dec      = 1'b0;
    idle_load     = 1'b0;
    idle_load_val = '0;
    idle_dec      = 1'b0;
    gate_off      = 1'b0;

    unique case (state_q)
      CLK_OFF: begin
        if (any_act) begin
          state_d   = CLK_WAKE;
          wake_load = 1'b1;
        end
      end
      CLK_WAKE: begin
        // Requests may vanish here; the clock still settles before ON.
        if (wake_zero) begin
          state_d = CLK_ON;
        end else begin
          wake_dec = 1'b1;
        end
      end
      CLK_ON: begin
        if (!any_act) begin
          if (IDLE_CYC == 0) begin
            // No drain window: gate off directly, still pulsing hysteresis.
            state_d  = CLK_OFF;
            gate_off = 1'b1;
          end else begin
            state_d       = CLK_DRAIN;
            idle_load     = 1'b1;
            idle_load_val = IDLE_W'(IDLE_LOAD);
          end
        end
      end
      CLK_DRAIN: begin
        // Fresh activity beats drain expiry.
        if (any_act) begin
          state_d       = CLK_ON;
          idle_load     = 1'b1;
          idle_load_val = '0;
        end else if (idle_zero) begin
          state_d  = CLK_OFF;
          gate_off = 1'b1;
        end else begin
          idle_dec = 1'b1;
        end
      end
      default: begin
        state_d = CLK_OFF;
      end
    endcase

    gate_en_d = (state_d != CLK_OFF);
    clk_on_d  = (state_d == CLK_ON) || (state_d == CLK_DRAIN);
    hyst_d    = gate_off;
    ack_d     = ((state_q == CLK_ON) || (state_q == CLK_DRAIN)) ? req_i : '0;
  end

  // State and output registers; reset aborts straight to OFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLK_OFF;
      gate_en_q <= 1'b0;
      hyst_q    <= 1'b0;
      clk_on_q  <= 1'b0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      gate_en_q <= gate_en_d;
      hyst_q    <= hyst_d;
      clk_on_q  <= clk_on_d;
      ack_q     <= ack_d;
    end
  end

  assign gate_en_o   = gate_en_q;
  assign gate_hyst_o = hyst_q;
  assign clk_on_o    = clk_on_q;
  assign ack_o       = ack_q;

`ifdef TT_DFD_CLK_REQ_STATS_EN
  logic [WAKE_COUNT_W-1:0] wake_count_q;
  logic [WAKE_COUNT_W-1:0] wake_count_d;
  logic [ON_CYCLES_W-1:0]  on_cycles_q;
  logic [ON_CYCLES_W-1:0]  on_cycles_d;

  // Wake count wraps, enabled-cycle count saturates; clear has priority.
  always_comb begin
    wake_count_d = wake_count_q;
    on_cycles_d  = on_cycles_q;
    if (stats_clr_i) begin
      wake_count_d = '0;
      on_cycles_d  = '0;
    end else begin
      if ((state_q == CLK_OFF) && (state_d == CLK_WAKE)) begin
        wake_count_d = wake_count_q + WAKE_COUNT_W'(1);
      end
      if (gate_en_q && (on_cycles_q != '1)) begin
        on_cycles_d = on_cycles_q + ON_CYCLES_W'(1);
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wake_count_q <= '0;
      on_cycles_q  <= '0;
    end else begin
      wake_count_q <= wake_count_d;
      on_cycles_q  <= on_cycles_d;
    end
  end

  assign wake_count_o = wake_count_q;
  assign on_cycles_o  = on_cycles_q;
`endif

`ifndef SYNTHESIS
  // Four-phase requester discipline: drop only while acked, raise only while unacked.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hs_chk
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      $fell(req_i[gi]) |-> ack_q[gi]);
    a_req_rearm: assert property (@(posedge clk) disable iff (rst)
      $rose(req_i[gi]) |-> !ack_q[gi]);
  end
`endif

endmodule

// File: tb/tb_tt_dfd_clk_req_ctrl.sv
// Directed + randomized bench for tt_dfd_clk_req_ctrl with a phase/timer reference model.
module tb_tt_dfd_clk_req_ctrl;

  localparam int NR   = 2;
  localparam int NB   = 1;
  localparam int WAKE = 2;
  localparam int IDLE = 4;

  localparam int P_OFF   = 0;
  localparam int P_WAKE  = 1;
  localparam int P_ON    = 2;
  localparam int P_DRAIN = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR-1:0] ack_o;
  logic [NB-1:0] busy;
  logic          force_en;
  logic          gate_en_o;
  logic          gate_hyst_o;
  logic          clk_on_o;
`ifdef TT_DFD_CLK_REQ_STATS_EN
  logic          stats_clr;
  logic [15:0]   wake_count_o;
  logic [31:0]   on_cycles_o;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: phase plus cycles remaining in the current timed phase.
  int            m_phase;
  int            m_wake_left;
  int            m_idle_left;
  logic [NR-1:0] m_ack;
  logic          m_hyst;
  int            en_run;
  logic [15:0]   m_wakes;
  logic [31:0]   m_oncyc;

  tt_dfd_clk_req_ctrl #(
    .NUM_REQ  (NR),
    .WAKE_CYC (WAKE),
    .IDLE_CYC (IDLE),
    .NUM_BUSY (NB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .ack_o        (ack_o),
    .busy_i       (busy),
    .force_en_i   (force_en),
`ifdef TT_DFD_CLK_REQ_STATS_EN
    .stats_clr_i  (stats_clr),
    .wake_count_o (wake_count_o),
    .on_cycles_o  (on_cycles_o),
`endif
    .gate_en_o    (gate_en_o),
    .gate_hyst_o  (gate_hyst_o),
    .clk_on_o     (clk_on_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    logic act;
    logic stats_clr_s;
    @(posedge clk);
    act = (|req) || (|busy) || force_en;
`ifdef TT_DFD_CLK_REQ_STATS_EN
    stats_clr_s = stats_clr;
`else
    stats_clr_s = 1'b0;
`endif
    if (rst) begin
      m_phase = P_OFF; m_ack = '0; m_hyst = 1'b0;
      m_wake_left = 0; m_idle_left = 0;
      m_wakes = '0; m_oncyc = '0;
    end else begin
      if (stats_clr_s) begin
        m_wakes = '0; m_oncyc = '0;
      end else begin
        if (m_phase == P_OFF && act) m_wakes = m_wakes + 16'd1;
        if (m_phase != P_OFF && m_oncyc != 32'hFFFF_FFFF) m_oncyc = m_oncyc + 32'd1;
      end
      m_hyst = 1'b0;
      m_ack  = (m_phase == P_ON || m_phase == P_DRAIN) ? req : '0;
      case (m_phase)
        P_OFF: if (act) begin m_phase = P_WAKE; m_wake_left = WAKE; end
        P_WAKE: begin
          m_wake_left--;
          if (m_wake_left == 0) m_phase = P_ON;
        end
        P_ON: if (!act) begin
          if (IDLE == 0) begin m_phase = P_OFF; m_hyst = 1'b1; end
          else begin m_phase = P_DRAIN; m_idle_left = IDLE; end
        end
        default: begin
          if (act) m_phase = P_ON;
          else begin
            m_idle_left--;
            if (m_idle_left == 0) begin m_phase = P_OFF; m_hyst = 1'b1; end
          end
        end
      endcase
    end
    #1;
    chk("gate_en", 32'(gate_en_o), 32'(m_phase != P_OFF));
    chk("ack", 32'(ack_o), 32'(m_ack));
    chk("gate_hyst", 32'(gate_hyst_o), 32'(m_hyst));
    chk("clk_on", 32'(clk_on_o), 32'(m_phase == P_ON || m_phase == P_DRAIN));
`ifdef TT_DFD_CLK_REQ_STATS_EN
    chk("wake_count", 32'(wake_count_o), 32'(m_wakes));
    chk("on_cycles", on_cycles_o, m_oncyc);
`endif
    // Ack only after the clock has been enabled for at least the wake window.
    if (ack_o != '0) chk("ack_after_wake", 32'(en_run >= WAKE), 32'd1);
    en_run = gate_en_o ? en_run + 1 : 0;
  endtask

  initial begin
    rst = 1'b1; req = '0; busy = '0; force_en = 1'b0;
    m_phase = P_OFF; m_ack = '0; m_hyst = 1'b0; en_run = 0;
    m_wake_left = 0; m_idle_left = 0; m_wakes = '0; m_oncyc = '0;
`ifdef TT_DFD_CLK_REQ_STATS_EN
    stats_clr = 1'b0;
`endif
    tick(); tick();
    chk("reset_gate", 32'(gate_en_o), 32'd0);
    chk("reset_ack", 32'(ack_o), 32'd0);
    rst = 1'b0;

    // Wake: req at cycle 0 -> gate at cycle 1, ack at cycle 4.
    req = 2'b01;
    tick();
    chk("first_gate", 32'(gate_en_o), 32'd1);
    tick(); chk("no_early_ack2", 32'(ack_o), 32'd0);
    tick(); chk("no_early_ack3", 32'(ack_o), 32'd0);
    tick(); chk("ack_cycle4", 32'(ack_o), 32'd1);

    // Drop req: ack falls next cycle, drain of IDLE cycles, one hyst pulse.
    req = 2'b00;
    tick(); chk("ack_fall", 32'(ack_o), 32'd0);
    for (int k = 0; k < IDLE - 1; k++) begin
      tick(); chk("drain_held", 32'(gate_en_o), 32'd1);
    end
    tick();
    chk("drain_off", 32'(gate_en_o), 32'd0);
    chk("hyst_pulse", 32'(gate_hyst_o), 32'd1);
    tick(); chk("hyst_single", 32'(gate_hyst_o), 32'd0);

    // Re-raise in the last drain cycle: stays ON.
    req = 2'b01;
    for (int k = 0; k < 20 && !(m_ack[0]); k++) tick();
    chk("wait_ack0", 32'(ack_o[0]), 32'd1);
    req = 2'b00;
    for (int k = 0; k < 20 && !(m_phase == P_DRAIN && m_idle_left == 1); k++) tick();
    chk("wait_last_drain", 32'(m_phase == P_DRAIN && m_idle_left == 1), 32'd1);
    req = 2'b10;
    tick();
    chk("rearm_gate", 32'(gate_en_o), 32'd1);
    chk("rearm_ack1", 32'(ack_o), 32'd2);
    chk("rearm_on", 32'(clk_on_o), 32'd1);
    req = 2'b00;
    for (int k = 0; k < 20 && m_phase != P_OFF; k++) tick();
    chk("wait_off1", 32'(gate_en_o), 32'd0);

    // Busy alone wakes and holds the clock without acks.
    busy = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("busy_on", 32'(clk_on_o), 32'd1);
    chk("busy_noack", 32'(ack_o), 32'd0);
    busy = 1'b0;
    for (int k = 0; k < IDLE + 3; k++) tick();

    // Reset during WAKE aborts with no hyst pulse.
    req = 2'b01;
    tick();
    chk("wake_gate", 32'(gate_en_o), 32'd1);
    rst = 1'b1; req = 2'b00;
    tick();
    chk("rst_gate", 32'(gate_en_o), 32'd0);
    chk("rst_hyst", 32'(gate_hyst_o), 32'd0);
    rst = 1'b0;
    tick();

    // Force enable holds the clock on.
    force_en = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    force_en = 1'b0;
    for (int k = 0; k < 8; k++) tick();

`ifdef TT_DFD_CLK_REQ_STATS_EN
    // Clear on a cycle that would also increment.
    req = 2'b01;
    for (int k = 0; k < 4; k++) tick();
    stats_clr = 1'b1;
    tick();
    chk("clr_wake", 32'(wake_count_o), 32'd0);
    chk("clr_oncyc", on_cycles_o, 32'd0);
    stats_clr = 1'b0;
    req = 2'b00;
    for (int k = 0; k < 10; k++) tick();
`endif

    // Randomized four-phase requesters with busy/force noise.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (req[i] && m_ack[i] && ($urandom_range(0, 2) == 0)) req[i] = 1'b0;
        else if (!req[i] && !m_ack[i] && ($urandom_range(0, 9) == 0)) req[i] = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) busy = ~busy;
      force_en = ($urandom_range(0, 40) == 0);
      rst = (c == 700);
`ifdef TT_DFD_CLK_REQ_STATS_EN
      stats_clr = ($urandom_range(0, 200) == 0);
`endif
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
